// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequencer and arbiter for the single-port data memory.
// Two requesters share the memory: the MEM pipeline stage (CPU port) and the
// program/debug loader (LD port). Each access runs IDLE -> BUSY -> RESP -> IDLE.
// During BUSY the memory sees a fixed MEM_LAT-cycle strobe. If the loader is
// kept waiting for STARVE_MAX CPU grants in a row, it wins the next grant.
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject misaligned word
// accesses. A rejected access skips the memory and raises acc_err.
module dmem_access_ctrl #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_memread,
  input  logic          cpu_memwrite,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_done,
  output logic          cpu_stall,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic [DW-1:0] ld_rdata,
  output logic          ld_ack,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          acc_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int          SW       = $clog2(STARVE_MAX + 1);
  localparam logic [3:0]  CNT_INIT = 4'(MEM_LAT - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [SW-1:0] streak;
  logic          owner_ld;   // 1: loader owns the current access
  logic          owner_we;   // 1: current access is a write
  logic          cpu_req;
  logic          grant_cpu;
  logic          grant_ld;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_wdata;
  logic          gnt_we;

  assign cpu_req = cpu_memread | cpu_memwrite;

  // Arbitration: the CPU wins by default; the loader wins when the CPU is idle
  // or the loader has waited out STARVE_MAX CPU grants.
  // NOTE: every signal gets a default at the top of always_comb, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_cpu = 1'b0;
    grant_ld  = 1'b0;
    if (state == S_IDLE) begin
      grant_ld  = ld_req & (~cpu_req | (streak == STREAK_MAX));
      grant_cpu = cpu_req & ~grant_ld;
    end
    gnt_addr  = grant_ld ? ld_addr  : cpu_addr;
    gnt_wdata = grant_ld ? ld_wdata : cpu_wdata;
    gnt_we    = grant_ld ? ld_we    : cpu_memwrite;  // read+write together counts as a write
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q;
  logic misaligned;
  assign misaligned = (gnt_addr[1:0] != 2'b00);
  assign acc_err    = (state == S_RESP) & err_q;
`else
  assign acc_err = 1'b0;
`endif

  // Access sequencer: latches the granted request, counts the memory cycles,
  // and captures the read data on the last BUSY cycle.
  // NOTE: all state registers use non-blocking assignments, so every register updates from the values present before the clock edge.
  // NOTE: the async reset clears every register, including the data latches, so no earlier access leaks onto a port after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      owner_ld  <= 1'b0;
      owner_we  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      ld_rdata  <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_cpu | grant_ld) begin
            mem_addr  <= gnt_addr;
            mem_wdata <= gnt_wdata;
            owner_ld  <= grant_ld;
            owner_we  <= gnt_we;
            cnt       <= CNT_INIT;
`ifdef DMEM_ALIGN_CHECK_EN
            err_q <= misaligned;
            if (misaligned) begin
              state <= S_RESP;
              if (grant_ld) ld_rdata  <= '0;
              else          cpu_rdata <= '0;
            end else begin
              state <= S_BUSY;
            end
`else
            state <= S_BUSY;
`endif
          end
        end
        S_BUSY: begin
          if (cnt == 4'd0) begin
            state <= S_RESP;
            if (owner_ld) ld_rdata  <= owner_we ? '0 : mem_rdata;
            else          cpu_rdata <= owner_we ? '0 : mem_rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Starvation streak: counts CPU grants taken while the loader was waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (!ld_req || grant_ld) begin
      streak <= '0;
    end else if (grant_cpu && streak != STREAK_MAX) begin
      streak <= streak + SW'(1);
    end
  end

  // Memory strobes and completion pulses are decoded from the registered state.
  always_comb begin
    mem_re    = (state == S_BUSY) & ~owner_we;
    mem_we    = (state == S_BUSY) &  owner_we;
    cpu_done  = (state == S_RESP) & ~owner_ld;
    ld_ack    = (state == S_RESP) &  owner_ld;
    cpu_stall = cpu_req & ~cpu_done;
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed testbench for dmem_access_ctrl with MEM_LAT=2 and STARVE_MAX=4.
// A small word-addressed memory model sits behind the mem_* port.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_memread, cpu_memwrite;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_done, cpu_stall;
  logic        ld_req, ld_we;
  logic [31:0] ld_addr, ld_wdata, ld_rdata;
  logic        ld_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_re, mem_we, acc_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] memarr [0:63];

  always #5 clk = ~clk;

  dmem_access_ctrl #(.AW(32), .DW(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_ack(ld_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .acc_err(acc_err)
  );

  assign mem_rdata = memarr[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_we) memarr[mem_addr[7:2]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) memarr[i] = 32'h0;
    rst_n = 1'b0;
    cpu_memread = 0; cpu_memwrite = 0; cpu_addr = 0; cpu_wdata = 0;
    ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
    #12;
    check("rst_mem_re", mem_re, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_done", cpu_done, 0);
    check("rst_ack", ld_ack, 0);
    check("rst_mem_addr", mem_addr, 0);
    rst_n = 1'b1;
    tick();

    // Test 1: CPU write 0x10 = DEADBEEF, then read it back.
    cpu_memwrite = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    #1;
    check("t1_stall_idle", cpu_stall, 1);
    check("t1_we_idle", mem_we, 0);
    tick();
    check("t1_we_b1", mem_we, 1);
    check("t1_addr_b1", mem_addr, 32'h10);
    check("t1_wdata_b1", mem_wdata, 32'hDEADBEEF);
    check("t1_stall_b1", cpu_stall, 1);
    tick();
    check("t1_we_b2", mem_we, 1);
    check("t1_done_b2", cpu_done, 0);
    tick();
    check("t1_we_resp", mem_we, 0);
    check("t1_done_resp", cpu_done, 1);
    check("t1_stall_resp", cpu_stall, 0);
    check("t1_rdata_wr", cpu_rdata, 0);
    cpu_memwrite = 0;
    tick();
    check("t1_done_idle", cpu_done, 0);
    check("t1_addr_hold", mem_addr, 32'h10);
    cpu_memread = 1; cpu_addr = 32'h10;
    tick();
    check("t1_re_b1", mem_re, 1);
    check("t1_we_rd", mem_we, 0);
    tick();
    check("t1_re_b2", mem_re, 1);
    tick();
    check("t1_rd_done", cpu_done, 1);
    check("t1_rdata", cpu_rdata, 32'hDEADBEEF);
    check("t1_re_resp", mem_re, 0);
    cpu_memread = 0;
    tick();

    // Test 3: loader write 0x20 = 12345678, then CPU read.
    ld_req = 1; ld_we = 1; ld_addr = 32'h20; ld_wdata = 32'h12345678;
    tick();
    check("t3_we_b1", mem_we, 1);
    check("t3_addr_b1", mem_addr, 32'h20);
    tick();
    check("t3_ack_b2", ld_ack, 0);
    tick();
    check("t3_ack", ld_ack, 1);
    check("t3_cpu_done", cpu_done, 0);
    ld_req = 0; ld_we = 0;
    tick();
    check("t3_ack_drop", ld_ack, 0);
    cpu_memread = 1; cpu_addr = 32'h20;
    tick(); tick(); tick();
    check("t3_cpu_done_rd", cpu_done, 1);
    check("t3_cpu_rdata", cpu_rdata, 32'h12345678);
    cpu_memread = 0;
    tick();

    // Test 2: CPU and loader both held; pattern C C C C L repeating.
    cpu_memread = 1; cpu_addr = 32'h10;
    ld_req = 1; ld_we = 0; ld_addr = 32'h20;
    for (int k = 0; k < 10; k++) begin
      tick(); tick(); tick();
      check($sformatf("t2_done_%0d", k), cpu_done, (k % 5 == 4) ? 0 : 1);
      check($sformatf("t2_ack_%0d", k), ld_ack, (k % 5 == 4) ? 1 : 0);
      tick();
    end
    check("t2_ld_rdata", ld_rdata, 32'h12345678);
    check("t2_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    cpu_memread = 0; ld_req = 0;
    tick();

    // Test 6: read and write together act as a write; cpu_rdata returns 0.
    cpu_memread = 1; cpu_memwrite = 1; cpu_addr = 32'h30; cpu_wdata = 32'hA5A5A5A5;
    tick();
    check("t6_we", mem_we, 1);
    check("t6_re", mem_re, 0);
    tick(); tick();
    check("t6_done", cpu_done, 1);
    check("t6_rdata", cpu_rdata, 0);
    cpu_memwrite = 0; cpu_addr = 32'h30;
    tick();
    tick(); tick(); tick();
    check("t6_readback", cpu_rdata, 32'hA5A5A5A5);
    cpu_memread = 0;
    tick();

    // Test 5: misaligned CPU read at 0x13.
    cpu_memread = 1; cpu_addr = 32'h13;
    tick();
`ifdef DMEM_ALIGN_CHECK_EN
    check("t5_no_re", mem_re, 0);
    check("t5_done", cpu_done, 1);
    check("t5_err", acc_err, 1);
    check("t5_rdata", cpu_rdata, 0);
    cpu_memread = 0;
    tick();
    check("t5_err_drop", acc_err, 0);
`else
    check("t5_re", mem_re, 1);
    check("t5_addr", mem_addr, 32'h13);
    check("t5_err_b", acc_err, 0);
    tick(); tick();
    check("t5_done", cpu_done, 1);
    check("t5_err", acc_err, 0);
    check("t5_rdata", cpu_rdata, 32'hDEADBEEF);
    cpu_memread = 0;
    tick();
`endif

    // Test 4: reset asserted during the second BUSY cycle of a write.
    cpu_memwrite = 1; cpu_addr = 32'h40; cpu_wdata = 32'h00000055;
    tick(); tick();
    check("t4_we_b2", mem_we, 1);
    rst_n = 0; cpu_memwrite = 0;
    #1;
    check("t4_we_rst", mem_we, 0);
    check("t4_re_rst", mem_re, 0);
    check("t4_addr_rst", mem_addr, 0);
    check("t4_wdata_rst", mem_wdata, 0);
    check("t4_cpu_rdata_rst", cpu_rdata, 0);
    check("t4_ld_rdata_rst", ld_rdata, 0);
    check("t4_done_rst", cpu_done, 0);
    check("t4_err_rst", acc_err, 0);
    #3;
    rst_n = 1;
    tick();
    check("t4_we_idle", mem_we, 0);
    check("t4_done_idle", cpu_done, 0);
    cpu_memread = 1; cpu_addr = 32'h20;
    tick();
    check("t4_re_after", mem_re, 1);
    tick(); tick();
    check("t4_done_after", cpu_done, 1);
    check("t4_rdata_after", cpu_rdata, 32'h12345678);
    cpu_memread = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
